// File: rtl/cpu_run_ctrl_if.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl_if
//
// Groups the board-side controls and the CPU-side run/step signals of the
// run/step controller into one bundle.
//
// Signals
//   btn          raw step pushbutton, active-high, asynchronous
//   run_sw       run switch level, synchronous to the system clock
//   halt_req     halt request level from the CPU, synchronous
//   cpu_start    CPU start/reset, high while the core is held in reset
//   cpu_ce       single-cycle CPU clock enable
//   state        controller state (00 RESET_HOLD, 01 HALT, 10 RUN, 11 STEP)
//   cycle_count  saturating count of issued cpu_ce pulses
//   btn_pulse    one-cycle pulse on a debounced btn rising edge
//
// Modports
//   master  the controller: samples the controls, drives the CPU-side outputs
//   slave   the surroundings: drive the controls, observe the outputs
// ---------------------------------------------------------------------------
interface cpu_run_ctrl_if #(
    parameter int CYC_W = 32
);
    logic             btn;
    logic             run_sw;
    logic             halt_req;
    logic             cpu_start;
    logic             cpu_ce;
    logic [1:0]       state;
    logic [CYC_W-1:0] cycle_count;
    logic             btn_pulse;

    modport master (
        input  btn, run_sw, halt_req,
        output cpu_start, cpu_ce, state, cycle_count, btn_pulse
    );

    modport slave (
        output btn, run_sw, halt_req,
        input  cpu_start, cpu_ce, state, cycle_count, btn_pulse
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_run_ctrl
//
// Run/step controller for the pipelined CPU core. After reset it holds the
// core in start/reset for RST_CYCLES cycles, then issues single-cycle clock
// enables: one every DIV_COUNT cycles in RUN, or one per debounced button
// press in STEP. A dropped run switch or a halt request returns it to HALT.
// Every issued enable is counted in a saturating cycle counter.
//
// Optional feature macro: RUN_CTRL_STEP_EN
//   defined   - btn synchronizer, debouncer and btn_pulse are built and the
//               STEP state is reachable
//   undefined - btn is ignored, btn_pulse is tied low, STEP is unreachable;
//               the state encoding does not change
//
// Ports
//   clk_signal  50 MHz system clock, all logic on its rising edge
//   reset       asynchronous active-high reset
//   bus         cpu_run_ctrl_if.master (btn, run_sw, halt_req in;
//               cpu_start, cpu_ce, state, cycle_count, btn_pulse out)
//
// Parameters
//   DIV_COUNT        clocks per cpu_ce pulse in RUN (>= 2)
//   DEBOUNCE_CYCLES  stable clocks needed to accept a btn level change
//   RST_CYCLES       clocks cpu_start is held after reset deasserts
//   CYC_W            cycle_count width (must match the interface)
// ---------------------------------------------------------------------------
module cpu_run_ctrl #(
    parameter int DIV_COUNT       = 25000000,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RST_CYCLES      = 4,
    parameter int CYC_W           = 32
) (
    input logic            clk_signal,
    input logic            reset,
    cpu_run_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        RESET_HOLD = 2'b00,
        HALT       = 2'b01,
        RUN        = 2'b10,
        STEP       = 2'b11
    } state_t;

    localparam int DIV_W  = $clog2(DIV_COUNT);
    localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV_COUNT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);

    state_t             state_q, state_next;
    logic [HOLD_W-1:0]  hold_q, hold_next;
    logic [DIV_W-1:0]   div_q, div_next;
    logic               ce_q, ce_next;
    logic               start_q;
    logic [CYC_W-1:0]   cycle_count_q;
    logic               step_req;

    // -----------------------------------------------------------------------
    // Step button path
    // -----------------------------------------------------------------------
`ifdef RUN_CTRL_STEP_EN
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            level_q, level_d_q;
    logic            btn_pulse_q;
    logic [DB_W-1:0] db_cnt_q;

    always_ff @(posedge clk_signal or posedge reset) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_d_q   <= 1'b0;
            btn_pulse_q <= 1'b0;
            db_cnt_q    <= '0;
        end else begin
            sync1_q     <= bus.btn;
            sync2_q     <= sync1_q;
            level_d_q   <= level_q;
            btn_pulse_q <= level_q & ~level_d_q;
            // The counter holds the number of mismatching cycles already seen,
            // so the cycle that would make it DEBOUNCE_CYCLES flips the level.
            if (sync2_q == level_q) begin
                db_cnt_q <= '0;
            end else if (db_cnt_q == DB_LAST) begin
                level_q  <= sync2_q;
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
        end
    end

    assign step_req      = btn_pulse_q;
    assign bus.btn_pulse = btn_pulse_q;
`else
    logic unused_btn;
    assign unused_btn    = bus.btn;
    assign step_req      = 1'b0;
    assign bus.btn_pulse = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Run/step FSM: next state, divider, hold counter and clock enable
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        state_next = state_q;
        hold_next  = hold_q;
        div_next   = div_q;
        ce_next    = 1'b0;

        case (state_q)
            RESET_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_next = HALT;
                end else begin
                    hold_next = hold_q + 1'b1;
                end
            end

            HALT: begin
                div_next = '0;
                // RUN is checked before the step pulse, so a coincident pulse
                // is dropped; halt_req blocks both.
                if (!bus.halt_req) begin
                    if (bus.run_sw) begin
                        state_next = RUN;
                    end else if (step_req) begin
                        state_next = STEP;
                        ce_next    = 1'b1;
                    end
                end
            end

            RUN: begin
                // Leaving RUN suppresses the enable even on terminal count.
                if (bus.halt_req || !bus.run_sw) begin
                    state_next = HALT;
                    div_next   = '0;
                end else if (div_q == DIV_LAST) begin
                    div_next = '0;
                    ce_next  = 1'b1;
                end else begin
                    div_next = div_q + 1'b1;
                end
            end

            STEP: begin
                state_next = HALT;
            end

            default: begin
                state_next = HALT;
            end
        endcase
    end

    always_ff @(posedge clk_signal or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q       <= RESET_HOLD;
            hold_q        <= '0;
            div_q         <= '0;
            ce_q          <= 1'b0;
            start_q       <= 1'b1;
            cycle_count_q <= '0;
        end else begin
            state_q <= state_next;
            hold_q  <= hold_next;
            div_q   <= div_next;
            ce_q    <= ce_next;
            start_q <= (state_next == RESET_HOLD);
            // Counts the enable already on the output, hence one cycle later.
            if (ce_q && (cycle_count_q != {CYC_W{1'b1}})) begin
                cycle_count_q <= cycle_count_q + 1'b1;
            end
        end
    end

    assign bus.cpu_start   = start_q;
    assign bus.cpu_ce      = ce_q;
    assign bus.state       = state_q;
    assign bus.cycle_count = cycle_count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_run_ctrl
//
// Directed bench for cpu_run_ctrl with DIV_COUNT=4, DEBOUNCE_CYCLES=8,
// RST_CYCLES=4. A second instance with CYC_W=3 covers counter saturation.
// Inputs change and outputs are sampled on the falling clock edge.
// Step scenarios are compiled when RUN_CTRL_STEP_EN is defined; otherwise
// the bench checks that btn is ignored.
// ---------------------------------------------------------------------------
module tb_cpu_run_ctrl;

    localparam logic [1:0] ST_HOLD = 2'b00;
    localparam logic [1:0] ST_HALT = 2'b01;
    localparam logic [1:0] ST_RUN  = 2'b10;
    localparam logic [1:0] ST_STEP = 2'b11;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   model_count;

    cpu_run_ctrl_if #(.CYC_W(32)) bus_if ();
    cpu_run_ctrl_if #(.CYC_W(3))  sat_if ();

    cpu_run_ctrl #(
        .DIV_COUNT(4), .DEBOUNCE_CYCLES(8), .RST_CYCLES(4), .CYC_W(32)
    ) dut (
        .clk_signal(clk),
        .reset     (reset),
        .bus       (bus_if)
    );

    cpu_run_ctrl #(
        .DIV_COUNT(4), .DEBOUNCE_CYCLES(8), .RST_CYCLES(4), .CYC_W(3)
    ) dut_sat (
        .clk_signal(clk),
        .reset     (reset),
        .bus       (sat_if)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // -----------------------------------------------------------------------
    task automatic test_reset();
        reset           = 1'b1;
        bus_if.btn      = 1'b0;
        bus_if.run_sw   = 1'b0;
        bus_if.halt_req = 1'b0;
        sat_if.btn      = 1'b0;
        sat_if.run_sw   = 1'b0;
        sat_if.halt_req = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (bus_if.state !== ST_HOLD || bus_if.cpu_start !== 1'b1 || bus_if.cpu_ce !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: state=%b start=%b ce=%b, required 00/1/0",
                     bus_if.state, bus_if.cpu_start, bus_if.cpu_ce);
        end
        total++;
        if (bus_if.cycle_count !== 32'd0 || bus_if.btn_pulse !== 1'b0) begin
            bad++;
            $display("FAIL reset_count: count=%0d pulse=%b, required 0/0",
                     bus_if.cycle_count, bus_if.btn_pulse);
        end
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            total++;
            if (bus_if.cpu_start !== (i < 4)) begin
                bad++;
                $display("FAIL hold_start[%0d]: cpu_start=%b required %b", i, bus_if.cpu_start, (i < 4));
            end
            total++;
            if (bus_if.state !== ((i < 4) ? ST_HOLD : ST_HALT)) begin
                bad++;
                $display("FAIL hold_state[%0d]: state=%b required %b", i, bus_if.state,
                         ((i < 4) ? ST_HOLD : ST_HALT));
            end
        end
        total++;
        if (bus_if.cpu_ce !== 1'b0 || bus_if.cycle_count !== 32'd0) begin
            bad++;
            $display("FAIL halt_after_reset: ce=%b count=%0d, required 0/0", bus_if.cpu_ce, bus_if.cycle_count);
        end
        model_count = 0;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_run();
        logic [31:0] exp_cnt;
        bus_if.run_sw = 1'b1;
        @(negedge clk);
        total++;
        if (bus_if.state !== ST_RUN || bus_if.cpu_ce !== 1'b0) begin
            bad++;
            $display("FAIL run_enter: state=%b ce=%b, required 10/0", bus_if.state, bus_if.cpu_ce);
        end
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            total++;
            if (bus_if.cpu_ce !== ((c % 4) == 0)) begin
                bad++;
                $display("FAIL run_ce[%0d]: ce=%b required %b", c, bus_if.cpu_ce, ((c % 4) == 0));
            end
            exp_cnt = 32'(model_count + (c - 1) / 4);
            total++;
            if (bus_if.cycle_count !== exp_cnt) begin
                bad++;
                $display("FAIL run_count[%0d]: count=%0d required %0d", c, bus_if.cycle_count, exp_cnt);
            end
        end
        bus_if.run_sw = 1'b0;
        model_count   = model_count + 10;
        @(negedge clk);
        total++;
        if (bus_if.state !== ST_HALT || bus_if.cpu_ce !== 1'b0) begin
            bad++;
            $display("FAIL run_stop: state=%b ce=%b, required 01/0", bus_if.state, bus_if.cpu_ce);
        end
        total++;
        if (bus_if.cycle_count !== 32'(model_count)) begin
            bad++;
            $display("FAIL run_total: count=%0d required %0d", bus_if.cycle_count, model_count);
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            total++;
            if (bus_if.cpu_ce !== 1'b0 || bus_if.state !== ST_HALT) begin
                bad++;
                $display("FAIL run_idle[%0d]: ce=%b state=%b, required 0/01", c, bus_if.cpu_ce, bus_if.state);
            end
        end
    endtask

`ifdef RUN_CTRL_STEP_EN
    // -----------------------------------------------------------------------
    task automatic test_step();
        bus_if.btn = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            total++;
            if (bus_if.btn_pulse !== (i == 11)) begin
                bad++;
                $display("FAIL step_pulse[%0d]: btn_pulse=%b required %b", i, bus_if.btn_pulse, (i == 11));
            end
            total++;
            if (bus_if.cpu_ce !== (i == 12) || bus_if.state !== ((i == 12) ? ST_STEP : ST_HALT)) begin
                bad++;
                $display("FAIL step_ce[%0d]: ce=%b state=%b, required %b/%b", i, bus_if.cpu_ce,
                         bus_if.state, (i == 12), ((i == 12) ? ST_STEP : ST_HALT));
            end
            total++;
            if (bus_if.cycle_count !== 32'(model_count + ((i >= 13) ? 1 : 0))) begin
                bad++;
                $display("FAIL step_count[%0d]: count=%0d required %0d", i, bus_if.cycle_count,
                         model_count + ((i >= 13) ? 1 : 0));
            end
        end
        model_count = model_count + 1;
        bus_if.btn  = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            total++;
            if (bus_if.btn_pulse !== 1'b0) begin
                bad++;
                $display("FAIL release_pulse[%0d]: btn_pulse=%b required 0", i, bus_if.btn_pulse);
            end
        end
        bus_if.btn = 1'b1;
        repeat (5) @(negedge clk);
        bus_if.btn = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if (bus_if.btn_pulse !== 1'b0 || bus_if.state !== ST_HALT) begin
                bad++;
                $display("FAIL glitch[%0d]: btn_pulse=%b state=%b, required 0/01", i, bus_if.btn_pulse, bus_if.state);
            end
        end
        total++;
        if (bus_if.cycle_count !== 32'(model_count)) begin
            bad++;
            $display("FAIL glitch_count: count=%0d required %0d", bus_if.cycle_count, model_count);
        end
    endtask
`else
    // -----------------------------------------------------------------------
    task automatic test_btn_ignored();
        bus_if.btn = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            total++;
            if (bus_if.btn_pulse !== 1'b0 || bus_if.state !== ST_HALT || bus_if.cpu_ce !== 1'b0) begin
                bad++;
                $display("FAIL btn_ignored[%0d]: pulse=%b state=%b ce=%b, required 0/01/0",
                         i, bus_if.btn_pulse, bus_if.state, bus_if.cpu_ce);
            end
        end
        bus_if.btn = 1'b0;
        total++;
        if (bus_if.cycle_count !== 32'(model_count)) begin
            bad++;
            $display("FAIL btn_ignored_count: count=%0d required %0d", bus_if.cycle_count, model_count);
        end
    endtask
`endif

    // -----------------------------------------------------------------------
    task automatic test_halt();
        bus_if.run_sw = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            total++;
            if (bus_if.cpu_ce !== 1'b0 || bus_if.state !== ST_RUN) begin
                bad++;
                $display("FAIL halt_prerun[%0d]: ce=%b state=%b, required 0/10", c, bus_if.cpu_ce, bus_if.state);
            end
        end
        // Divider now sits at its terminal count.
        bus_if.halt_req = 1'b1;
        @(negedge clk);
        total++;
        if (bus_if.state !== ST_HALT || bus_if.cpu_ce !== 1'b0) begin
            bad++;
            $display("FAIL halt_at_terminal: state=%b ce=%b, required 01/0", bus_if.state, bus_if.cpu_ce);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            total++;
            if (bus_if.state !== ST_HALT || bus_if.cpu_ce !== 1'b0) begin
                bad++;
                $display("FAIL halt_hold_run[%0d]: state=%b ce=%b, required 01/0", c, bus_if.state, bus_if.cpu_ce);
            end
        end
`ifdef RUN_CTRL_STEP_EN
        begin
            int pulses;
            pulses          = 0;
            bus_if.run_sw   = 1'b0;
            bus_if.btn      = 1'b1;
            for (int i = 1; i <= 20; i++) begin
                @(negedge clk);
                if (bus_if.btn_pulse === 1'b1) pulses++;
                total++;
                if (bus_if.state !== ST_HALT || bus_if.cpu_ce !== 1'b0) begin
                    bad++;
                    $display("FAIL halt_hold_step[%0d]: state=%b ce=%b, required 01/0", i, bus_if.state, bus_if.cpu_ce);
                end
            end
            total++;
            if (pulses !== 1) begin
                bad++;
                $display("FAIL halt_btn_pulses: pulses=%0d required 1", pulses);
            end
            bus_if.btn = 1'b0;
            repeat (14) @(negedge clk);
        end
`endif
        bus_if.run_sw   = 1'b0;
        bus_if.halt_req = 1'b0;
        @(negedge clk);
        total++;
        if (bus_if.state !== ST_HALT || bus_if.cycle_count !== 32'(model_count)) begin
            bad++;
            $display("FAIL halt_release: state=%b count=%0d, required 01/%0d",
                     bus_if.state, bus_if.cycle_count, model_count);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_saturation();
        sat_if.run_sw = 1'b1;
        @(negedge clk);
        total++;
        if (sat_if.state !== ST_RUN || sat_if.cycle_count !== 3'd0) begin
            bad++;
            $display("FAIL sat_enter: state=%b count=%0d, required 10/0", sat_if.state, sat_if.cycle_count);
        end
        for (int c = 1; c <= 44; c++) begin
            @(negedge clk);
            if (c == 29 || c == 37 || c == 44) begin
                total++;
                if (sat_if.cycle_count !== 3'd7) begin
                    bad++;
                    $display("FAIL sat_count[%0d]: count=%0d required 7", c, sat_if.cycle_count);
                end
            end
        end
        sat_if.run_sw = 1'b0;
        @(negedge clk);
        total++;
        if (sat_if.state !== ST_HALT || sat_if.cycle_count !== 3'd7) begin
            bad++;
            $display("FAIL sat_stop: state=%b count=%0d, required 01/7", sat_if.state, sat_if.cycle_count);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_async_reset();
        bus_if.run_sw = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 8; c++) @(negedge clk);
        total++;
        if (bus_if.cpu_ce !== 1'b1 || bus_if.cycle_count !== 32'(model_count + 1)) begin
            bad++;
            $display("FAIL areset_pre: ce=%b count=%0d, required 1/%0d",
                     bus_if.cpu_ce, bus_if.cycle_count, model_count + 1);
        end
        #3 reset = 1'b1;
        #1;
        total++;
        if (bus_if.cpu_start !== 1'b1 || bus_if.cpu_ce !== 1'b0) begin
            bad++;
            $display("FAIL areset_outputs: start=%b ce=%b, required 1/0", bus_if.cpu_start, bus_if.cpu_ce);
        end
        total++;
        if (bus_if.state !== ST_HOLD || bus_if.cycle_count !== 32'd0) begin
            bad++;
            $display("FAIL areset_state: state=%b count=%0d, required 00/0", bus_if.state, bus_if.cycle_count);
        end
        @(negedge clk);
        bus_if.run_sw = 1'b0;
        reset         = 1'b0;
        model_count   = 0;
        repeat (4) @(negedge clk);
        total++;
        if (bus_if.state !== ST_HALT || bus_if.cpu_start !== 1'b0 || bus_if.cycle_count !== 32'd0) begin
            bad++;
            $display("FAIL areset_recover: state=%b start=%b count=%0d, required 01/0/0",
                     bus_if.state, bus_if.cpu_start, bus_if.cycle_count);
        end
    endtask

    // -----------------------------------------------------------------------
    initial begin
        total       = 0;
        bad         = 0;
        model_count = 0;
        test_reset();
        test_run();
`ifdef RUN_CTRL_STEP_EN
        test_step();
`else
        test_btn_ignored();
`endif
        test_halt();
        test_saturation();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/step controller that sequences the pipelined CPU core from the 50 MHz board clock. It holds the core in start/reset for a fixed number of cycles, then issues single-cycle clock-enable pulses to the core: periodically in run mode, or one per debounced button press in step mode. It stops on a run switch or a halt request from the core, and counts issued CPU cycles for display and debug. It sits between the board pins and the CPU, and replaces the free-running toggle divider.

## Interface
- DIV_COUNT, 25000000: clk_signal cycles per cpu_ce pulse in RUN; must be ≥2.
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles needed to accept a btn level change.
- RST_CYCLES, 4: cycles cpu_start is held after reset deasserts.
- CYC_W, 32: cycle_count width.

- clk_signal  in  1  50 MHz system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- btn  in  1  raw asynchronous step pushbutton, active-high.
- run_sw  in  1  run switch; level, synchronous to clk_signal.
- halt_req  in  1  halt request from CPU; level, synchronous.
- cpu_start  out  1  CPU start/reset; high in RESET_HOLD.
- cpu_ce  out  1  single-cycle CPU clock enable.
- state  out  2  FSM state: RESET_HOLD=00, HALT=01, RUN=10, STEP=11.
- cycle_count  out  CYC_W  number of cpu_ce pulses issued; saturating.
- btn_pulse  out  1  one-cycle pulse on debounced btn rising edge.

## Operation
- Reset values: state=RESET_HOLD, cpu_start=1, cpu_ce=0, cycle_count=0, btn_pulse=0, divider=0, debounce counter=0, debounced level=0.
- RESET_HOLD: hold counter counts 0..RST_CYCLES-1, then go to HALT. cpu_start is high for exactly RST_CYCLES cycles after reset deasserts.
- HALT: cpu_ce=0, divider held at 0.
  - If run_sw=1 and halt_req=0, go to RUN.
  - Otherwise, if btn_pulse=1 and halt_req=0, go to STEP.
  - If run_sw and btn_pulse are both valid, RUN wins and the pulse is dropped.
- RUN: divider counts 0..DIV_COUNT-1 and wraps. cpu_ce=1 in the cycle after the divider reaches DIV_COUNT-1.
  - halt_req=1 or run_sw=0 sends the FSM to HALT next cycle and clears the divider. No cpu_ce is issued in that cycle, even if terminal count coincides.
  - halt_req takes priority over all other transitions.
- STEP: cpu_ce=1 for exactly one cycle, then back to HALT unconditionally. btn_pulse arriving in STEP is dropped.
- cycle_count increments by 1 on every cpu_ce cycle and saturates at 2^CYC_W-1 (no wrap).
- Debounce path:
  - btn passes a 2-flop synchronizer.
  - A counter increments while the synchronized value differs from the debounced level, and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the new value and the counter clears.
  - btn_pulse is registered and fires on a 0→1 transition of the debounced level.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Any in-flight cpu_ce is suppressed.

## Timing
- All outputs are registered; there are no combinational input→output paths.
- btn rising edge → btn_pulse: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles, provided btn stays stable throughout.
- btn_pulse in HALT → STEP next cycle → cpu_ce high in the STEP cycle. Total btn_pulse → cpu_ce is 1 cycle.
- run_sw 0→1 in HALT → RUN next cycle → first cpu_ce DIV_COUNT cycles after entering RUN. After that, cpu_ce has period DIV_COUNT.
- halt_req or run_sw drop → state=HALT on the next edge.
- cycle_count updates on the same edge that samples cpu_ce=1, so it is visible one cycle after the pulse.

## Configuration
- RUN_CTRL_STEP_EN defined:
  - Synchronizer, debounce and btn_pulse logic are present.
  - The STEP state is reachable.
- RUN_CTRL_STEP_EN undefined:
  - btn is ignored and no debounce logic is built.
  - btn_pulse is tied to 0 and STEP is unreachable.
  - The state encoding is unchanged.

## Test plan
Parameters for all scenarios: DIV_COUNT=4, DEBOUNCE_CYCLES=8, RST_CYCLES=4.
- Reset: assert reset for 3 cycles, then release with run_sw=0 → cpu_start=1 for 4 cycles, then state=01, cpu_ce=0, cycle_count=0.
- Run: set run_sw=1 in HALT → state=10 next cycle, cpu_ce pulses every 4 cycles. After 10 pulses cycle_count=10. Drop run_sw → state=01 next cycle, no further pulses.
- Step (RUN_CTRL_STEP_EN): hold btn high for 20 cycles → exactly one btn_pulse at cycle 11, one cpu_ce, cycle_count +1, state back to 01. A 5-cycle btn glitch → no btn_pulse.
- Halt: halt_req=1 in RUN at a divider terminal count → no cpu_ce, state=01. With halt_req held, neither run_sw=1 nor btn_pulse leaves HALT.
- Saturation: CYC_W=3, run 10 pulses → cycle_count stays 7.
- Async reset during RUN between clock edges → cpu_start=1 and cpu_ce=0 immediately, state=00, cycle_count=0.
